// File: rtl/pfb_snap_pkg.sv
// Shared constants for the pfb_out snapshot capture path.
// Holds the FSM state encoding and the default BRAM port A geometry, which the
// ramblk wrapper instantiation uses as well.
package pfb_snap_pkg;

  localparam int unsigned PFB_SNAP_DATA_W = 64;
  localparam int unsigned PFB_SNAP_ADDR_W = 10;

  localparam int unsigned STATE_W = 2;
  typedef logic [STATE_W-1:0] snap_state_t;

  localparam snap_state_t IDLE    = 2'd0;
  localparam snap_state_t ARMED   = 2'd1;
  localparam snap_state_t CAPTURE = 2'd2;
  localparam snap_state_t DONE    = 2'd3;

endpackage

// File: rtl/pfb_out_snap_ctrl.sv
// Capture controller for the pfb_out snapshot BRAM.
// After a rising edge on arm, and optionally a frame sync, it writes exactly
// 2**ADDR_W consecutive valid PFB words into BRAM port A. It then holds done
// until software re-arms.
// Ports:
//   clk, rst_n      fabric clock (shared with BRAM port A), async active-low reset
//   din, din_valid  PFB output word and its qualifier
//   sync_in         frame sync, coincident with the first word of a frame
//   arm             software arm bit; a capture starts on its rising edge
//   trig_mode       0 = start at next sync_in, 1 = start at next din_valid
//   bram_we, bram_en_a, bram_addr, bram_wr_data   registered BRAM port A write port
//   busy            high while ARMED or CAPTURE
//   done            high while DONE; the buffer holds a complete snapshot
module pfb_out_snap_ctrl
  import pfb_snap_pkg::*;
#(
  parameter int unsigned DATA_W = PFB_SNAP_DATA_W,
  parameter int unsigned ADDR_W = PFB_SNAP_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] din,
  input  logic              din_valid,
  input  logic              sync_in,
  input  logic              arm,
  input  logic              trig_mode,
  output logic              bram_we,
  output logic              bram_en_a,
  output logic [ADDR_W-1:0] bram_addr,
  output logic [DATA_W-1:0] bram_wr_data,
  output logic              busy,
  output logic              done
);

  // One extra pointer bit so the final address is distinguishable from wrap.
  localparam int unsigned PTR_W = ADDR_W + 1;
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(2**ADDR_W - 1);

  snap_state_t       state;
  snap_state_t       next_state;
  logic              arm_d;
  logic              arm_rise;
  logic              accept;
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  wr_ptr_nxt;
  logic              we_d;
  logic [ADDR_W-1:0] addr_d;
  logic              busy_d;
  logic              done_d;

  assign arm_rise = arm & ~arm_d;
  assign accept   = din_valid & (trig_mode | sync_in);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic. arm edges outside IDLE/DONE are ignored, so an edge
  // coinciding with the final write is consumed without re-arming.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (arm_rise) next_state = ARMED;
      ARMED:   if (accept) next_state = CAPTURE;
      CAPTURE: if (din_valid && (wr_ptr == LAST_PTR)) next_state = DONE;
      DONE:    if (arm_rise) next_state = ARMED;
      default: next_state = IDLE;
    endcase
  end

  // Output / datapath decode, registered below.
  always_comb begin
    we_d       = 1'b0;
    addr_d     = wr_ptr[ADDR_W-1:0];
    wr_ptr_nxt = wr_ptr;
    case (state)
      ARMED: begin
        if (accept) begin
          we_d       = 1'b1;
          addr_d     = '0;
          wr_ptr_nxt = PTR_W'(1);
        end
      end
      CAPTURE: begin
        if (din_valid) begin
          we_d       = 1'b1;
          wr_ptr_nxt = wr_ptr + PTR_W'(1);
        end
      end
      default: ;
    endcase
    // Status tracks the state being entered so done lines up with the last write.
    busy_d = (next_state == ARMED) || (next_state == CAPTURE);
    done_d = (next_state == DONE);
  end

  // Arm edge detector, write pointer and registered BRAM write port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      arm_d        <= 1'b0;
      wr_ptr       <= '0;
      bram_we      <= 1'b0;
      bram_en_a    <= 1'b0;
      bram_addr    <= '0;
      bram_wr_data <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      arm_d     <= arm;
      wr_ptr    <= wr_ptr_nxt;
      bram_we   <= we_d;
      bram_en_a <= we_d;
      busy      <= busy_d;
      done      <= done_d;
      if (we_d) begin
        bram_addr    <= addr_d;
        bram_wr_data <= din;
      end
    end
  end

endmodule

// File: tb/tb_pfb_out_snap_ctrl.sv
// Self-checking bench for pfb_out_snap_ctrl: scenario tasks push expected
// BRAM writes into a scoreboard queue; a negedge monitor pops and compares.
module tb_pfb_out_snap_ctrl;

  localparam int unsigned DATA_W = 64;
  localparam int unsigned ADDR_W = 10;
  localparam int          DEPTH  = 1 << ADDR_W;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_t;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [DATA_W-1:0] din = '0;
  logic              din_valid = 1'b0;
  logic              sync_in = 1'b0;
  logic              arm = 1'b0;
  logic              trig_mode = 1'b0;
  logic              bram_we;
  logic              bram_en_a;
  logic [ADDR_W-1:0] bram_addr;
  logic [DATA_W-1:0] bram_wr_data;
  logic              busy;
  logic              done;

  int checks = 0;
  int errors = 0;
  int wr_count = 0;
  wr_t sb[$];

  pfb_out_snap_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid),
    .sync_in(sync_in), .arm(arm), .trig_mode(trig_mode),
    .bram_we(bram_we), .bram_en_a(bram_en_a), .bram_addr(bram_addr),
    .bram_wr_data(bram_wr_data), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Scoreboard monitor: every write must match the next expected write in order.
  always @(negedge clk) begin
    wr_t exp_wr;
    if (rst_n) begin
      checks++;
      if ((busy && done) || (bram_en_a !== bram_we)) begin
        errors++;
        $display("FAIL status_consistency busy=%b done=%b en_a=%b we=%b", busy, done, bram_en_a, bram_we);
      end
      if (bram_we) begin
        wr_count++;
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_write addr=%0d data=%0h (no write expected)", bram_addr, bram_wr_data);
        end else begin
          exp_wr = sb.pop_front();
          if (bram_addr !== exp_wr.addr || bram_wr_data !== exp_wr.data) begin
            errors++;
            $display("FAIL write_content got addr=%0d data=%0h expected addr=%0d data=%0h",
                     bram_addr, bram_wr_data, exp_wr.addr, exp_wr.data);
          end
          if (exp_wr.addr == ADDR_W'(DEPTH - 1)) begin
            checks++;
            if (done !== 1'b1 || busy !== 1'b0) begin
              errors++;
              $display("FAIL done_at_last_write got done=%b busy=%b expected done=1 busy=0", done, busy);
            end
          end
        end
      end
    end
  end

  // Rising edge on arm, then confirm the controller reports ARMED.
  task automatic arm_pulse();
    @(posedge clk); #1;
    arm = 1'b1;
    @(posedge clk); #1;
    arm = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL arm_response got busy=%b done=%b expected busy=1 done=0", busy, done);
    end
  endtask

  // Drive n_words valid words (data = base+k) with gap idle cycles after each.
  // Pushes the words that should be captured: from the trigger word on, 2**ADDR_W of them.
  task automatic run_stream(input int n_words, input int gap, input bit imm,
                            input int sync_word, input int arm_on, input int arm_off,
                            input logic [DATA_W-1:0] base, output int captured);
    bit started = 1'b0;
    bit sync_now;
    int cap = 0;
    trig_mode = imm;
    for (int k = 0; k < n_words; k++) begin
      @(posedge clk); #1;
      sync_now  = (k == sync_word) || (sync_word >= 0 && k == sync_word + 500);
      din       = base + DATA_W'(k);
      din_valid = 1'b1;
      sync_in   = sync_now;
      if (k == arm_on)  arm = 1'b1;
      if (k == arm_off) arm = 1'b0;
      if (!started && (imm || sync_now)) started = 1'b1;
      if (started && cap < DEPTH) begin
        sb.push_back('{addr: ADDR_W'(cap), data: base + DATA_W'(k)});
        cap++;
      end
      for (int g = 0; g < gap; g++) begin
        @(posedge clk); #1;
        din_valid = 1'b0;
        sync_in   = 1'b0;
        din       = ~din;
      end
    end
    @(posedge clk); #1;
    din_valid = 1'b0;
    sync_in   = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    captured = cap;
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if (bram_we !== 1'b0 || bram_en_a !== 1'b0 || bram_addr !== '0 || bram_wr_data !== '0 ||
        busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_values got we=%b en=%b addr=%0d data=%0h busy=%b done=%b expected all 0",
               bram_we, bram_en_a, bram_addr, bram_wr_data, busy, done);
    end
    @(negedge clk);
    rst_n = 1'b1;
    // Valid data with no arm edge must not be captured.
    trig_mode = 1'b1;
    repeat (5) begin
      @(posedge clk); #1;
      din_valid = 1'b1;
      din = din + 1;
    end
    @(posedge clk); #1;
    din_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (wr_count !== 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_no_write got writes=%0d busy=%b expected 0 0", wr_count, busy);
    end
  endtask

  task automatic test_immediate();
    int w0 = wr_count;
    int cap;
    arm_pulse();
    run_stream(DEPTH + 6, 0, 1'b1, -1, -1, -1, 64'd0, cap);
    checks++;
    if (wr_count - w0 !== DEPTH || sb.size() != 0 || done !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL immediate_end got writes=%0d pending=%0d done=%b busy=%b expected %0d 0 1 0",
               wr_count - w0, sb.size(), done, busy, DEPTH);
    end
  endtask

  task automatic test_sync();
    int w0 = wr_count;
    int cap;
    arm_pulse();
    run_stream(1100, 0, 1'b0, 37, -1, -1, 64'd0, cap);
    checks++;
    if (wr_count - w0 !== DEPTH || sb.size() != 0 || done !== 1'b1) begin
      errors++;
      $display("FAIL sync_end got writes=%0d pending=%0d done=%b expected %0d 0 1",
               wr_count - w0, sb.size(), done, DEPTH);
    end
  endtask

  task automatic test_gapped();
    int w0 = wr_count;
    int cap;
    arm_pulse();
    run_stream(DEPTH + 4, 2, 1'b1, -1, -1, -1, 64'hA5A5_0000_0000_0100, cap);
    checks++;
    if (wr_count - w0 !== cap || cap !== DEPTH || sb.size() != 0 || done !== 1'b1) begin
      errors++;
      $display("FAIL gapped_end got writes=%0d valid_in_capture=%0d pending=%0d done=%b expected %0d",
               wr_count - w0, cap, sb.size(), done, DEPTH);
    end
  endtask

  task automatic test_rearm();
    int w0 = wr_count;
    int cap;
    // Re-arm from DONE; arm toggles mid-capture must not restart or abort.
    arm_pulse();
    run_stream(DEPTH + 8, 0, 1'b1, -1, 300, 305, 64'hFEED_0000_0000_0000, cap);
    checks++;
    if (wr_count - w0 !== DEPTH || sb.size() != 0 || done !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rearm_end got writes=%0d pending=%0d done=%b busy=%b expected %0d 0 1 0",
               wr_count - w0, sb.size(), done, busy, DEPTH);
    end
  endtask

  task automatic test_corner_arm_at_last();
    int w0 = wr_count;
    int cap;
    arm_pulse();
    // arm rises on the final captured word; trailing valid words reveal any re-arm.
    run_stream(DEPTH + 10, 0, 1'b1, -1, DEPTH - 1, -1, 64'h0000_0C0C_0000_0000, cap);
    checks++;
    if (wr_count - w0 !== DEPTH || sb.size() != 0 || done !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL corner_end got writes=%0d pending=%0d done=%b busy=%b expected %0d 0 1 0",
               wr_count - w0, sb.size(), done, busy, DEPTH);
    end
    @(posedge clk); #1;
    arm = 1'b0;
  endtask

  task automatic test_reset_mid();
    int w0 = wr_count;
    arm_pulse();
    trig_mode = 1'b1;
    for (int k = 0; k <= 500; k++) begin
      @(posedge clk); #1;
      din = 64'h0000_0500_0000_0000 + DATA_W'(k);
      din_valid = 1'b1;
      if (k < 500) sb.push_back('{addr: ADDR_W'(k), data: 64'h0000_0500_0000_0000 + DATA_W'(k)});
    end
    @(posedge clk); #2;
    checks++;
    if (bram_we !== 1'b1 || bram_addr !== ADDR_W'(500)) begin
      errors++;
      $display("FAIL pre_reset_write got we=%b addr=%0d expected we=1 addr=500", bram_we, bram_addr);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (bram_we !== 1'b0 || bram_en_a !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_capture got we=%b en=%b busy=%b done=%b expected all 0",
               bram_we, bram_en_a, busy, done);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) begin
      @(posedge clk); #1;
      din = din + 1;
      din_valid = 1'b1;
    end
    @(posedge clk); #1;
    din_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (wr_count - w0 !== 500 || sb.size() != 0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_idle got writes=%0d pending=%0d busy=%b done=%b expected 500 0 0 0",
               wr_count - w0, sb.size(), busy, done);
    end
  endtask

  initial begin
    test_reset();
    test_immediate();
    test_sync();
    test_gapped();
    test_rearm();
    test_corner_arm_at_last();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
